// File: rtl/tpu_seq_ctrl.sv
// Mini-TPU sequencer: takes A then B as a 32-byte stream, issues LOAD/RUN/STORE
// words on the instruction bus and returns the 16 result bytes as a stream.
module tpu_seq_ctrl #(
  parameter int RUN_CYCLES = 11,
  parameter int STORE_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic [15:0] instr,
  input  logic [7:0]  tpu_result
);

  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_RUN   = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b11;
  localparam logic [7:0] RUN_LAST  = 8'(RUN_CYCLES - 1);
  localparam logic [1:0] WAIT_LAST = 2'(STORE_LAT);

  typedef enum logic [2:0] {
    IDLE, LOAD_A, LOAD_B, RUN, ST_ISSUE, ST_WAIT, ST_OUT
  } state_t;

  state_t     state;
  logic [3:0] idx;
  logic [7:0] run_cnt;
  logic [1:0] wait_cnt;
  logic       in_hs;
  logic       out_hs;

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  function automatic logic [15:0] mk_instr(input logic [1:0] op, input logic sel,
                                           input logic [3:0] i, input logic [7:0] d);
    return {1'b0, op, sel, i, d};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      run_cnt   <= '0;
      wait_cnt  <= '0;
      instr     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      instr <= '0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx      <= '0;
            busy     <= 1'b1;
            in_ready <= 1'b1;
            state    <= LOAD_A;
          end
        end
        LOAD_A, LOAD_B: begin
          if (in_hs) begin
            instr <= mk_instr(OP_LOAD, state == LOAD_B, idx, in_data);
            idx   <= idx + 4'd1;
            if (idx == 4'd15) begin
              if (state == LOAD_A) begin
                state <= LOAD_B;
              end else begin
                in_ready <= 1'b0;
                run_cnt  <= '0;
                state    <= RUN;
              end
            end
          end
        end
        RUN: begin
          instr   <= mk_instr(OP_RUN, 1'b0, 4'd0, 8'd0);
          run_cnt <= run_cnt + 8'd1;
          if (run_cnt == RUN_LAST) begin
            idx   <= '0;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          instr    <= mk_instr(OP_STORE, 1'b0, idx, 8'd0);
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          // wait_cnt is 0 in the cycle the STORE word sits on instr
          if (wait_cnt == WAIT_LAST) begin
            out_data  <= tpu_result;
            out_valid <= 1'b1;
            out_last  <= (idx == 4'd15);
            state     <= ST_OUT;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        ST_OUT: begin
          if (out_hs) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (idx == 4'd15) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              // The handshake cycle doubles as the issue slot for the next
              // STORE, giving one result every STORE_LAT+2 cycles.
              idx      <= idx + 4'd1;
              instr    <= mk_instr(OP_STORE, 1'b0, idx + 4'd1, 8'd0);
              wait_cnt <= '0;
              state    <= ST_WAIT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
